// File: rtl/kmeans_pkg.sv
// rtl/kmeans_pkg.sv - shared constants, FSM encoding and centroid packing for the k-means centroid update
package kmeans_pkg;

    localparam int K              = 4;
    localparam int N              = 2;
    localparam int CENTROID_IDX_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_DIV    = 3'd2,
        ST_WRITE  = 3'd3,
        ST_COMMIT = 3'd4
    } cu_state_e;

    // Packing order: coordinate (k, d) sits at slot k*N + d, slot 0 in the LSBs,
    // i.e. {k3d1, k3d0, k2d1, k2d0, k1d1, k1d0, k0d1, k0d0}.
    function automatic int coord_lsb(input logic [CENTROID_IDX_W-1:0] k, input int d, input int w);
        return (int'(k) * N + d) * w;
    endfunction

endpackage

// File: rtl/kmeans_centroid_update_k4n2_if.sv
// rtl/kmeans_centroid_update_k4n2_if.sv - accumulator read-port bundle between the centroid update and the accumulator
// Signals: rd_acc_en / rd_acc_centroid (address side), acc0_output / acc1_output /
// acc_counter_output (combinational data returned for the addressed centroid).
// master = centroid update block, slave = accumulator.
interface kmeans_centroid_update_k4n2_if #(
    parameter int DATA_QTY_W = 8,
    parameter int ACC_W      = 16
);
    import kmeans_pkg::*;

    logic                      rd_acc_en;
    logic [CENTROID_IDX_W-1:0] rd_acc_centroid;
    logic [ACC_W-1:0]          acc0_output;
    logic [ACC_W-1:0]          acc1_output;
    logic [DATA_QTY_W-1:0]     acc_counter_output;

    modport master (
        output rd_acc_en, rd_acc_centroid,
        input  acc0_output, acc1_output, acc_counter_output
    );

    modport slave (
        input  rd_acc_en, rd_acc_centroid,
        output acc0_output, acc1_output, acc_counter_output
    );

endinterface

// File: rtl/kmeans_seq_divider.sv
// rtl/kmeans_seq_divider.sv - restoring sequential divider, one quotient bit per cycle, saturating quotient
// Ports: clk, rst_n (async active-low), start (loads operands), dividend, divisor,
// busy (iterations outstanding), done (high in the cycle of the final iteration,
// quotient valid from the next cycle), quotient (saturated to QUOTIENT_W bits).
module kmeans_seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8,
    parameter int QUOTIENT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOTIENT_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    // quo_q starts as the dividend and is shifted left; quotient bits enter at the LSB.
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVISOR_W:0]    rem_shift;
    logic [DIVISOR_W:0]    rem_sub;

    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        rem_shift = {rem_q, quo_q[DIVIDEND_W-1]};
        rem_sub   = rem_shift - {1'b0, dsr_q};
        if (start) begin
            quo_d = dividend;
            rem_d = '0;
            dsr_d = divisor;
            cnt_d = CNT_W'(DIVIDEND_W);
        end else if (cnt_q != '0) begin
            // The stored remainder is always below the divisor, so it fits DIVISOR_W bits.
            if (rem_shift >= {1'b0, dsr_q}) begin
                rem_d = rem_sub[DIVISOR_W-1:0];
                quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[DIVISOR_W-1:0];
                quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        busy     = (cnt_q != '0);
        done     = (cnt_q == CNT_W'(1));
        quotient = (|quo_q[DIVIDEND_W-1:QUOTIENT_W]) ? '1 : quo_q[QUOTIENT_W-1:0];
    end

endmodule

// File: rtl/kmeans_centroid_update_k4n2.sv
// rtl/kmeans_centroid_update_k4n2.sv - reads accumulator sums/counts, divides, commits new centroids, reports convergence
// Ports: clk, rst_n (async active-low), start (pulse, accepted in IDLE only),
// acc (accumulator read port, master side), centroids (packed, registered),
// busy, done (one-cycle pulse at COMMIT), converged (valid with done, held until next done).
// Optional: KMEANS_CU_ROUND_EN selects round-half-up division (one extra DIV cycle).
module kmeans_centroid_update_k4n2
    import kmeans_pkg::*;
#(
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16,
    parameter logic [input_data_width-1:0] k0_d0_initial = input_data_width'(0),
    parameter logic [input_data_width-1:0] k0_d1_initial = input_data_width'(0),
    parameter logic [input_data_width-1:0] k1_d0_initial = input_data_width'(1),
    parameter logic [input_data_width-1:0] k1_d1_initial = input_data_width'(1),
    parameter logic [input_data_width-1:0] k2_d0_initial = input_data_width'(2),
    parameter logic [input_data_width-1:0] k2_d1_initial = input_data_width'(2),
    parameter logic [input_data_width-1:0] k3_d0_initial = input_data_width'(3),
    parameter logic [input_data_width-1:0] k3_d1_initial = input_data_width'(3)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    kmeans_centroid_update_k4n2_if.master       acc,
    output logic [K*N*input_data_width-1:0]     centroids,
    output logic                                busy,
    output logic                                done,
    output logic                                converged
);

    localparam int W  = input_data_width;
    localparam int CW = K * N * W;
    localparam logic [CW-1:0] INIT = {k3_d1_initial, k3_d0_initial, k2_d1_initial, k2_d0_initial,
                                      k1_d1_initial, k1_d0_initial, k0_d1_initial, k0_d0_initial};

`ifdef KMEANS_CU_ROUND_EN
    localparam int DIV_W = acc_width + 1;
`else
    localparam int DIV_W = acc_width;
`endif

    cu_state_e                 state_q, state_d;
    logic [CENTROID_IDX_W-1:0] idx_q, idx_d;
    logic                      zero_q, zero_d;
    logic                      changed_q, changed_d;
    logic                      converged_q, converged_d;
    logic [CW-1:0]             shadow_q, shadow_d;
    logic [CW-1:0]             centroids_q, centroids_d;

    logic             div_start;
    logic [DIV_W-1:0] dividend0, dividend1;
    logic             div0_busy, div1_busy, div0_done, div1_done;
    logic [W-1:0]     q0, q1, live0, live1;

    always_comb begin
`ifdef KMEANS_CU_ROUND_EN
        // Adding half the divisor before a floor division gives round-half-up.
        dividend0 = {1'b0, acc.acc0_output} + DIV_W'(acc.acc_counter_output >> 1);
        dividend1 = {1'b0, acc.acc1_output} + DIV_W'(acc.acc_counter_output >> 1);
`else
        dividend0 = acc.acc0_output;
        dividend1 = acc.acc1_output;
`endif
        div_start = (state_q == ST_READ) && (acc.acc_counter_output != '0);
    end

    kmeans_seq_divider #(.DIVIDEND_W(DIV_W), .DIVISOR_W(input_data_qty_bit_width), .QUOTIENT_W(W)) u_div0 (
        .clk(clk), .rst_n(rst_n), .start(div_start), .dividend(dividend0),
        .divisor(acc.acc_counter_output), .busy(div0_busy), .done(div0_done), .quotient(q0)
    );

    kmeans_seq_divider #(.DIVIDEND_W(DIV_W), .DIVISOR_W(input_data_qty_bit_width), .QUOTIENT_W(W)) u_div1 (
        .clk(clk), .rst_n(rst_n), .start(div_start), .dividend(dividend1),
        .divisor(acc.acc_counter_output), .busy(div1_busy), .done(div1_done), .quotient(q1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            zero_q      <= 1'b0;
            changed_q   <= 1'b0;
            converged_q <= 1'b0;
            shadow_q    <= '0;
            centroids_q <= INIT;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            zero_q      <= zero_d;
            changed_q   <= changed_d;
            converged_q <= converged_d;
            shadow_q    <= shadow_d;
            centroids_q <= centroids_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        zero_d      = zero_q;
        changed_d   = changed_q;
        converged_d = converged_q;
        shadow_d    = shadow_q;
        centroids_d = centroids_q;
        live0       = centroids_q[coord_lsb(idx_q, 0, W) +: W];
        live1       = centroids_q[coord_lsb(idx_q, 1, W) +: W];
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_READ;
                    idx_d     = '0;
                    changed_d = 1'b0;
                end
            end
            ST_READ: begin
                zero_d  = (acc.acc_counter_output == '0);
                state_d = (acc.acc_counter_output == '0) ? ST_WRITE : ST_DIV;
            end
            ST_DIV: begin
                if (div0_done && div1_done) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // An empty (or wrapped) count keeps the live coordinates.
                if (zero_q) begin
                    shadow_d[coord_lsb(idx_q, 0, W) +: W] = live0;
                    shadow_d[coord_lsb(idx_q, 1, W) +: W] = live1;
                end else begin
                    shadow_d[coord_lsb(idx_q, 0, W) +: W] = q0;
                    shadow_d[coord_lsb(idx_q, 1, W) +: W] = q1;
                    changed_d = changed_q | (q0 != live0) | (q1 != live1);
                end
                if (idx_q == CENTROID_IDX_W'(K - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_COMMIT: begin
                centroids_d = shadow_q;
                converged_d = ~changed_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc.rd_acc_en       = (state_q == ST_READ);
        acc.rd_acc_centroid = (state_q == ST_IDLE) ? '0 : idx_q;
        centroids           = centroids_q;
        busy                = (state_q != ST_IDLE) | div0_busy | div1_busy;
        done                = (state_q == ST_COMMIT);
        converged           = (state_q == ST_COMMIT) ? ~changed_q : converged_q;
    end

endmodule

// File: tb/tb_kmeans_centroid_update_k4n2.sv
// tb/tb_kmeans_centroid_update_k4n2.sv - directed self-checking bench for kmeans_centroid_update_k4n2
module tb_kmeans_centroid_update_k4n2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] centroids;
    logic        busy, done, converged;

    logic [15:0] sum0_m [4];
    logic [15:0] sum1_m [4];
    logic [7:0]  cnt_m  [4];

    int n_pass = 0;
    int n_checks = 0;

    localparam logic [63:0] INIT  = {8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};
    localparam logic [63:0] RES_A = {8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd6, 8'd3};
    localparam logic [63:0] RES_D = {8'd2, 8'd255, 8'd5, 8'd2, 8'd1, 8'd1, 8'd5, 8'd255};
`ifdef KMEANS_CU_ROUND_EN
    localparam logic [63:0] RES_C = {8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd3, 8'd4};
    localparam int LAT_A = 26;
    localparam int LAT_D = 60;
`else
    localparam logic [63:0] RES_C = {8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd3, 8'd3};
    localparam int LAT_A = 25;
    localparam int LAT_D = 57;
`endif

    always #5 clk = ~clk;

    kmeans_centroid_update_k4n2_if acc_if ();

    kmeans_centroid_update_k4n2 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc(acc_if),
        .centroids(centroids), .busy(busy), .done(done), .converged(converged)
    );

    always_comb begin
        acc_if.acc0_output        = sum0_m[acc_if.rd_acc_centroid];
        acc_if.acc1_output        = sum1_m[acc_if.rd_acc_centroid];
        acc_if.acc_counter_output = cnt_m[acc_if.rd_acc_centroid];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_c(input int k, input int s0, input int s1, input int c);
        sum0_m[k] = 16'(s0);
        sum1_m[k] = 16'(s1);
        cnt_m[k]  = 8'(c);
    endtask

    task automatic do_pass(input string tag, input bit extra, input logic [63:0] prev,
                           input logic [63:0] exp_c, input int exp_lat, input bit exp_conv);
        int cyc, ens, extra_done;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        ens = 0;
        while (cyc < 400) begin
            if (acc_if.rd_acc_en) ens++;
            if (cyc == 10) check({tag, "_stable_mid"}, centroids, prev);
            if (done) break;
            start = extra && (cyc % 7 == 3);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_rd_en_cycles"}, 64'(ens), 64'd4);
        check({tag, "_cent_at_done"}, centroids, prev);
        check({tag, "_conv_at_done"}, 64'(converged), 64'(exp_conv));
        @(negedge clk);
        check({tag, "_centroids"}, centroids, exp_c);
        check({tag, "_idle_flags"}, {61'd0, busy, done, converged}, {61'd0, 1'b0, 1'b0, exp_conv});
        if (extra) begin
            extra_done = 0;
            repeat (40) @(negedge clk) if (done) extra_done++;
            check({tag, "_no_extra_done"}, 64'(extra_done), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 4; k++) set_c(k, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_centroids", centroids, INIT);
        check("reset_flags", {60'd0, acc_if.rd_acc_en, busy, done, converged}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_flags", {60'd0, acc_if.rd_acc_en, busy, done, converged}, 64'd0);

        // Basic pass: only c0 populated; c1 carries a nonzero sum with zero count.
        set_c(0, 30, 60, 10);
        set_c(1, 500, 500, 0);
        do_pass("basic", 1'b0, INIT, RES_A, LAT_A, 1'b0);
        do_pass("converge", 1'b0, RES_A, RES_A, LAT_A, 1'b1);

        set_c(0, 7, 6, 2);
        do_pass("round", 1'b0, RES_A, RES_C, LAT_A, 1'b0);

        // Saturation (1000/1, 65535/255), wrap retention (c1), ordinary c2.
        set_c(0, 1000, 5, 1);
        set_c(2, 9, 20, 4);
        set_c(3, 65535, 510, 255);
        do_pass("sat", 1'b0, RES_C, RES_D, LAT_D, 1'b0);
        do_pass("start_busy", 1'b1, RES_D, RES_D, LAT_D, 1'b1);

        // Reset during DIV of c0.
        set_c(0, 30, 60, 10);
        set_c(2, 0, 0, 0);
        set_c(3, 0, 0, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_mid_div", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_centroids", centroids, INIT);
        check("midreset_flags", {60'd0, acc_if.rd_acc_en, busy, done, converged}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        do_pass("after_reset", 1'b0, INIT, RES_A, LAT_A, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kmeans_centroid_update_k4n2.md
Name: kmeans_centroid_update_k4n2

Overview:
Downstream consumer of kmeans_acc_block_k4n2. It reads each centroid's accumulated dimension sums and point count through the accumulator's read port, then divides sums by count to form new centroids. It owns the live centroid registers that feed kmeans_pipeline_k4_d2 and reports convergence after each update pass. The K-means controller runs it once per iteration, after the accumulation pass has drained.

Parameters:
input_data_width, 8, width of one centroid coordinate
input_data_qty_bit_width, 8, width of the per-centroid point counter
acc_width, 16, width of the accumulator sums
k0_d0_initial .. k3_d1_initial, 0,0,1,1,2,2,3,3, reset values of the eight centroid coordinates

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  single-cycle pulse; begins one update pass
rd_acc_en  out  1  drives the accumulator rd_acc_en
rd_acc_centroid  out  2  drives the accumulator rd_acc_centroid
acc0_output  in  acc_width  dimension-0 sum; combinational from the accumulator, same cycle as the address
acc1_output  in  acc_width  dimension-1 sum; same timing as acc0_output
acc_counter_output  in  input_data_qty_bit_width  point count for rd_acc_centroid; same timing
centroids  out  8*input_data_width  packed {k3d1,k3d0,k2d1,k2d0,k1d1,k1d0,k0d1,k0d0}, registered
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at the end of a pass
converged  out  1  valid with done and held until the next done; 1 = no coordinate changed

Behaviour:
- Reset values (asynchronous on rst_n low):
  - centroids = initial parameters; rd_acc_en=0; rd_acc_centroid=0; busy=0; done=0; converged=0.
  - FSM returns to IDLE; the shadow registers clear.
- Reset mid-pass aborts the pass; nothing partial is committed.
- FSM states: IDLE, READ, DIV, WRITE, COMMIT.
  - IDLE: start=1 → READ with idx=0. start is ignored in every other state.
  - READ (1 cycle): rd_acc_en=1, rd_acc_centroid=idx. Latch both sums and the count.
    - count==0 → WRITE, keeping the old coordinates.
    - Otherwise → DIV.
  - DIV (exactly acc_width cycles): two restoring dividers run in lockstep, one per dimension. Divisor is the count; remainder width is input_data_qty_bit_width+1.
  - WRITE (1 cycle): store the quotients in shadow regs for idx and set the sticky changed flag if either differs from the live value.
    - idx==3 → COMMIT.
    - Otherwise idx+1 → READ.
  - COMMIT (1 cycle): all 8 shadows load into centroids at once; done=1; converged=~changed. Then → IDLE.
- rd_acc_en is 1 only in READ. rd_acc_centroid holds idx in all non-IDLE states.
- Latency: start at edge t → done high in cycle t+N.
  - N = sum over centroids of (acc_width+2 if count≠0, else 2), plus 1.
  - All four counts nonzero with acc_width=16 gives N=73.
- Arithmetic: quotient is truncated (floor). A quotient above 2^input_data_width-1 saturates to all-ones.
- Count wrap: count==0 always retains the old centroid, even if the sum is nonzero (counter overflow in the accumulator).
- Centroids stay stable during the whole pass and change only in COMMIT.

Optional Feature:
- KMEANS_CU_ROUND_EN defined: the dividend becomes sum + (count>>1), widened to acc_width+1 bits. DIV then lasts acc_width+1 cycles, giving round-half-up.
- Undefined: floor division, with DIV lasting acc_width cycles.

Decomposition:
- kmeans_pkg holds: K=4, N=2, CENTROID_IDX_W=2, the FSM state encoding, and the centroid packing order.
- One sub-module, kmeans_seq_divider: start/busy/done handshake, parameterised dividend/divisor widths, saturating quotient. It is instantiated twice and both instances share the FSM start.

Test Plan:
- Reset: release rst_n → centroids = {3,3,2,2,1,1,0,0}, busy=0, done=0.
- Basic pass:
  - Stimulus: c0 sums=(30,60), count=10; c1..c3 count=0; start.
  - Response: done at t+25; k0=(3,6); k1..k3 unchanged; converged=0; rd_acc_en high in exactly 4 cycles.
- Convergence: repeat the same pass → identical centroids, converged=1.
- Rounding:
  - c0 sum0=7, count=2 → k0d0=3 without the macro.
  - With KMEANS_CU_ROUND_EN → k0d0=4, and done timing grows by 1 cycle per nonzero centroid.
- Saturation/wrap:
  - sum0=1000, count=1 → k0d0=255.
  - sum0=500, count=0 → old value retained.
- Control:
  - start pulses while busy → no effect and no extra done.
  - rst_n low mid-DIV → immediate reset values; next start completes a full, correct pass.
